soc_ram_arb: RTL and testbench
==============================

SOC_RAM_ARB -- requirements
Module: soc_ram_arb

Interface
REQ-001 Parameter DATA_WIDTH, default 16, word width in bits; SHALL be a multiple of 8, range 16..64.
REQ-002 Parameter ADDR_MSB, default 6, MSB of the word address; address width = ADDR_MSB+1.
REQ-003 Parameter MEM_SIZE, default 256, memory size in bytes; depth = MEM_SIZE/(DATA_WIDTH/8) words, at most 2^(ADDR_MSB+1).
REQ-004 Derived NB = DATA_WIDTH/8 byte lanes.
REQ-005 Clocking and reset: one clock and an asynchronous, active-low reset.
REQ-006 clka  in  1  single clock; all state samples on the rising edge.
REQ-007 rst_n  in  1  asynchronous active-low reset.
REQ-008 req0 / req1  in  1  port 0 / port 1 access request, held until granted.
REQ-009 we0 / we1  in  NB  per-byte write enables; all-zero means read.
REQ-010 addr0 / addr1  in  ADDR_MSB+1  word address.
REQ-011 din0 / din1  in  DATA_WIDTH  write data.
REQ-012 gnt0 / gnt1  out  1  combinational grant; the access executes at the clock edge ending the granted cycle.
REQ-013 rvalid0 / rvalid1  out  1  one-cycle pulse; read data is valid on dout.
REQ-014 dout  out  DATA_WIDTH  registered read data, shared by both ports.
REQ-015 err  out  1  one-cycle pulse flagging an out-of-range access.

Function
REQ-016 Storage SHALL be a single-port array of depth words; at most one access per cycle.
REQ-017 gntN SHALL assert only when reqN=1; gnt0 and gnt1 SHALL never assert together.
REQ-018 If exactly one request is active, that request SHALL be granted in the same cycle.
REQ-019 If both requests are active, the port not granted most recently SHALL win (round-robin); the last-grant pointer SHALL update only on a grant.
REQ-020 A granted write SHALL update only the byte lanes whose we bit is 1; the other lanes SHALL keep their value.
REQ-021 A granted read (we=0) SHALL load dout at the grant edge and pulse rvalidN for exactly the following cycle; read latency is 1 cycle.
REQ-022 dout SHALL hold its last value until the next read; writes SHALL NOT change dout.
REQ-023 A granted write SHALL NOT pulse rvalid.
REQ-024 Back-to-back reads SHALL be possible, one per cycle, alternating ports under contention with no bubble.
REQ-025 A granted access with addr >= depth SHALL write nothing, load dout with 0, still pulse rvalid if it is a read, and pulse err for one cycle.
REQ-026 A requester that drops req before being granted SHALL cause no access; the pointer SHALL remain unchanged.

Reset
REQ-027 On rst_n=0, immediately: rvalid0=rvalid1=0, err=0, dout=0, last-grant pointer=1 (port 0 wins the first tie).
REQ-028 gnt0 and gnt1 SHALL be forced to 0 while rst_n=0.
REQ-029 Memory contents SHALL NOT be reset.
REQ-030 A reset asserted mid-access SHALL drop any pending rvalid or err pulse; the write executing at that edge is undefined.
REQ-031 After rst_n deasserts, the first clock edge SHALL accept a grant.

Verification
REQ-032 Write 0xA5A5 to addr 3 via port 0 with we0=11, then read addr 3 via port 1 -> gnt1 in the read cycle; rvalid1=1 and dout=0xA5A5 one cycle later; rvalid0 stays 0.
REQ-033 Byte-lane write: with addr 5 holding 0x1234, write 0xABCD with we0=01 -> a subsequent read returns 0x12CD.
REQ-034 Simultaneous reads of addr 1 and addr 2 on 4 consecutive cycles after reset -> grants in the order port 0, 1, 0, 1; each rvalid is matched to its own address data.
REQ-035 Read of addr = depth (128 at default parameters) -> dout=0, rvalid pulses, err pulses once; array unchanged (a full-array readback matches the model).
REQ-036 rst_n pulsed low on the cycle after a read grant -> rvalid, err and dout forced to 0 asynchronously; the next tie grants port 0.
REQ-037 Repeat REQ-032 to REQ-035 with DATA_WIDTH=32, NB=4 and MEM_SIZE=1024 -> identical behaviour per byte lane.

Source files
------------

// File: rtl/soc_ram_arb.sv
// soc_ram_arb: two-port round-robin arbiter in front of a single-port,
// byte-lane-writable RAM with a shared registered read-data output.
//
// Ports:
//   clka            single clock, rising edge
//   rst_n           asynchronous active-low reset
//   req0/req1       access requests, held until granted
//   we0/we1         per-byte write enables (all zero = read)
//   addr0/addr1     word addresses
//   din0/din1       write data
//   gnt0/gnt1       combinational grants; access executes at the closing edge
//   rvalid0/rvalid1 one-cycle read-data-valid pulses
//   dout            registered read data shared by both ports
//   err             one-cycle pulse for an out-of-range access
module soc_ram_arb #(
    parameter int unsigned DATA_WIDTH = 16,
    parameter int unsigned ADDR_MSB   = 6,
    parameter int unsigned MEM_SIZE   = 256
) (
    input  logic                      clka,
    input  logic                      rst_n,
    input  logic                      req0,
    input  logic                      req1,
    input  logic [DATA_WIDTH/8-1:0]   we0,
    input  logic [DATA_WIDTH/8-1:0]   we1,
    input  logic [ADDR_MSB:0]         addr0,
    input  logic [ADDR_MSB:0]         addr1,
    input  logic [DATA_WIDTH-1:0]     din0,
    input  logic [DATA_WIDTH-1:0]     din1,
    output logic                      gnt0,
    output logic                      gnt1,
    output logic                      rvalid0,
    output logic                      rvalid1,
    output logic [DATA_WIDTH-1:0]     dout,
    output logic                      err
);

    localparam int unsigned NB    = DATA_WIDTH / 8;
    localparam int unsigned AW    = ADDR_MSB + 1;
    localparam int unsigned CW    = AW + 1;
    localparam int unsigned DEPTH = MEM_SIZE / NB;
    localparam int unsigned IW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    // r_last = 1 means port 1 was granted most recently
    logic                  r_last;
    logic                  r_rvalid0;
    logic                  r_rvalid1;
    logic                  r_err;
    logic [DATA_WIDTH-1:0] r_dout;
    logic [DATA_WIDTH-1:0] r_mem [DEPTH];

    logic                  w_gnt0;
    logic                  w_gnt1;
    logic                  w_any;
    logic                  w_rd;
    logic                  w_in_range;
    logic [NB-1:0]         w_we;
    logic [ADDR_MSB:0]     w_addr;
    logic [DATA_WIDTH-1:0] w_din;
    logic [IW-1:0]         w_idx;

    // Round-robin grant; a tie goes to the port not granted last
    always_comb begin
        w_gnt0 = 1'b0;
        w_gnt1 = 1'b0;
        if (rst_n) begin
            if (req0 && req1) begin
                w_gnt0 = r_last;
                w_gnt1 = ~r_last;
            end else begin
                w_gnt0 = req0;
                w_gnt1 = req1;
            end
        end
    end

    // Granted-port request mux
    always_comb begin
        w_any      = w_gnt0 | w_gnt1;
        w_we       = w_gnt1 ? we1   : we0;
        w_addr     = w_gnt1 ? addr1 : addr0;
        w_din      = w_gnt1 ? din1  : din0;
        w_rd       = w_any & ~(|w_we);
        // One extra bit so DEPTH == 2^AW compares correctly
        w_in_range = {1'b0, w_addr} < CW'(DEPTH);
        w_idx      = w_addr[IW-1:0];
    end

    // Control and read-data registers
    always_ff @(posedge clka or negedge rst_n) begin
        if (!rst_n) begin
            r_last    <= 1'b1;
            r_rvalid0 <= 1'b0;
            r_rvalid1 <= 1'b0;
            r_err     <= 1'b0;
            r_dout    <= '0;
        end else begin
            r_rvalid0 <= w_gnt0 & w_rd;
            r_rvalid1 <= w_gnt1 & w_rd;
            r_err     <= w_any & ~w_in_range;
            if (w_any) begin
                r_last <= w_gnt1;
            end
            if (w_rd) begin
                r_dout <= w_in_range ? r_mem[w_idx] : '0;
            end
        end
    end

    // Storage array: byte-lane writes, never reset
    always_ff @(posedge clka) begin
        if (w_any && w_in_range) begin
            for (int b = 0; b < int'(NB); b++) begin
                if (w_we[b]) begin
                    r_mem[w_idx][b*8 +: 8] <= w_din[b*8 +: 8];
                end
            end
        end
    end

    assign gnt0    = w_gnt0;
    assign gnt1    = w_gnt1;
    assign rvalid0 = r_rvalid0;
    assign rvalid1 = r_rvalid1;
    assign dout    = r_dout;
    assign err     = r_err;

endmodule

// File: tb/tb_soc_ram_arb.sv
// tb_soc_ram_arb: two instances (16-bit/128 words and 32-bit/256 words, each
// with one spare address bit so out-of-range addresses can be driven), a
// per-cycle reference model and directed scenarios with literal expectations.
module tb_soc_ram_arb;

    logic clk = 1'b0;
    logic rst_n = 1'b1;

    logic        req0 [2];
    logic        req1 [2];
    logic [7:0]  we0  [2];
    logic [7:0]  we1  [2];
    logic [8:0]  addr0[2];
    logic [8:0]  addr1[2];
    logic [63:0] din0 [2];
    logic [63:0] din1 [2];
    logic        gnt0 [2];
    logic        gnt1 [2];
    logic        rvalid0[2];
    logic        rvalid1[2];
    logic        err  [2];
    logic [63:0] dout [2];

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    for (genvar g = 0; g < 2; g++) begin : g_dut
        localparam int unsigned DW   = (g == 0) ? 16 : 32;
        localparam int unsigned AMSB = (g == 0) ? 7 : 8;
        localparam int unsigned MS   = (g == 0) ? 256 : 1024;
        localparam int unsigned NB   = DW / 8;
        logic [DW-1:0] w_dout;
        soc_ram_arb #(.DATA_WIDTH(DW), .ADDR_MSB(AMSB), .MEM_SIZE(MS)) u_dut (
            .clka   (clk),
            .rst_n  (rst_n),
            .req0   (req0[g]),
            .req1   (req1[g]),
            .we0    (we0[g][NB-1:0]),
            .we1    (we1[g][NB-1:0]),
            .addr0  (addr0[g][AMSB:0]),
            .addr1  (addr1[g][AMSB:0]),
            .din0   (din0[g][DW-1:0]),
            .din1   (din1[g][DW-1:0]),
            .gnt0   (gnt0[g]),
            .gnt1   (gnt1[g]),
            .rvalid0(rvalid0[g]),
            .rvalid1(rvalid1[g]),
            .dout   (w_dout),
            .err    (err[g])
        );
        assign dout[g] = 64'(w_dout);
    end

    function automatic int depth(int k);
        return (k == 0) ? 128 : 256;
    endfunction

    function automatic int nbytes(int k);
        return (k == 0) ? 2 : 4;
    endfunction

    function automatic logic [63:0] wmask(int k);
        return (k == 0) ? 64'h0000_0000_0000_FFFF : 64'h0000_0000_FFFF_FFFF;
    endfunction

    function automatic logic [63:0] pat(int k, int a);
        logic [7:0] a8;
        a8 = 8'(a);
        return (64'h0F1E_2D3C_4B5A_6978 ^ {8{a8}}) & wmask(k);
    endfunction

    task automatic chk(string nm, int k, logic [63:0] act, logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s dut%0d got=%h exp=%h t=%0t", nm, k, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    bit [63:0] mdl [2][256];
    int        last_port[2];
    bit        e_rv0[2];
    bit        e_rv1[2];
    bit        e_err[2];
    bit [63:0] e_dout[2];

    always @(negedge clk) begin
        for (int k = 0; k < 2; k++) begin
            int        win;
            int        a;
            bit [7:0]  w;
            bit [63:0] d;
            bit        g0;
            bit        g1;
            if (!rst_n) begin
                e_rv0[k] = 1'b0; e_rv1[k] = 1'b0; e_err[k] = 1'b0;
                e_dout[k] = '0;  last_port[k] = 1;
            end
            win = -1;
            if (rst_n) begin
                if (req0[k] && req1[k]) win = 1 - last_port[k];
                else if (req0[k])       win = 0;
                else if (req1[k])       win = 1;
            end
            g0 = (win == 0);
            g1 = (win == 1);
            chk("gnt0",    k, 64'(gnt0[k]),    64'(g0));
            chk("gnt1",    k, 64'(gnt1[k]),    64'(g1));
            chk("rvalid0", k, 64'(rvalid0[k]), 64'(e_rv0[k]));
            chk("rvalid1", k, 64'(rvalid1[k]), 64'(e_rv1[k]));
            chk("err",     k, 64'(err[k]),     64'(e_err[k]));
            chk("dout",    k, dout[k],         e_dout[k]);
            e_rv0[k] = 1'b0; e_rv1[k] = 1'b0; e_err[k] = 1'b0;
            if (win >= 0) begin
                a = (win == 1) ? int'(addr1[k]) : int'(addr0[k]);
                w = (win == 1) ? we1[k] : we0[k];
                d = (win == 1) ? din1[k] : din0[k];
                for (int b = nbytes(k); b < 8; b++) w[b] = 1'b0;
                e_err[k] = (a >= depth(k));
                if (w == 8'h00) begin
                    e_dout[k] = (a < depth(k)) ? mdl[k][a] : 64'h0;
                    e_rv0[k]  = g0;
                    e_rv1[k]  = g1;
                end else if (a < depth(k)) begin
                    for (int b = 0; b < 8; b++)
                        if (w[b]) mdl[k][a][b*8 +: 8] = d[b*8 +: 8];
                end
                last_port[k] = win;
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(int k);
        req0[k] = 1'b0; req1[k] = 1'b0;
        we0[k] = '0; we1[k] = '0;
    endtask

    task automatic single(int k, int p, logic [7:0] w, logic [8:0] a, logic [63:0] d);
        idle(k);
        if (p == 0) begin
            req0[k] = 1'b1; we0[k] = w; addr0[k] = a; din0[k] = d;
        end else begin
            req1[k] = 1'b1; we1[k] = w; addr1[k] = a; din1[k] = d;
        end
    endtask

    task automatic do_reset();
        @(posedge clk);
        #2 rst_n = 1'b0;
        @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    task automatic run_tests(int k);
        logic [63:0] a5;
        logic [63:0] exp_bl;
        a5     = 64'hA5A5_A5A5_A5A5_A5A5 & wmask(k);
        exp_bl = (k == 0) ? 64'h12CD : 64'h1234_5601;

        // write 0xA5.. to addr 3 via port 0, read it back via port 1
        single(k, 0, 8'hFF, 9'd3, 64'hA5A5_A5A5_A5A5_A5A5);
        cyc();
        single(k, 1, 8'h00, 9'd3, 64'h0);
        #1;
        chk("lit_rd_gnt1", k, 64'(gnt1[k]), 64'd1);
        chk("lit_rd_gnt0", k, 64'(gnt0[k]), 64'd0);
        cyc();
        idle(k);
        chk("lit_rd_rvalid1", k, 64'(rvalid1[k]), 64'd1);
        chk("lit_rd_rvalid0", k, 64'(rvalid0[k]), 64'd0);
        chk("lit_rd_dout",    k, dout[k],          a5);

        // byte-lane write: only lane 0 changes
        single(k, 0, 8'hFF, 9'd5, 64'h1234_5678_1234_1234 & ((k == 0) ? 64'hFFFF : 64'hFFFF_FFFF));
        if (k == 1) din0[k] = 64'h1234_5678;
        cyc();
        single(k, 0, 8'h01, 9'd5, (k == 0) ? 64'hABCD : 64'hABCD_EF01);
        cyc();
        single(k, 0, 8'h00, 9'd5, 64'h0);
        cyc();
        idle(k);
        chk("lit_lane_dout", k, dout[k], exp_bl);

        // out-of-range write must not alias onto addr 3; out-of-range read
        single(k, 1, 8'hFF, 9'(depth(k) + 3), 64'hDEAD_BEEF_DEAD_BEEF);
        cyc();
        chk("lit_oobw_err", k, 64'(err[k]), 64'd1);
        single(k, 0, 8'h00, 9'(depth(k)), 64'h0);
        cyc();
        idle(k);
        chk("lit_oob_err",    k, 64'(err[k]),     64'd1);
        chk("lit_oob_rvalid", k, 64'(rvalid0[k]), 64'd1);
        chk("lit_oob_dout",   k, dout[k],         64'd0);
        cyc();
        chk("lit_oob_err_once", k, 64'(err[k]), 64'd0);
        for (int a = 0; a < depth(k); a++) begin
            single(k, a % 2, 8'h00, 9'(a), 64'h0);
            cyc();
        end
        idle(k);
        cyc();

        // contention after reset: 0,1,0,1 with per-port data
        do_reset();
        req0[k] = 1'b1; we0[k] = '0; addr0[k] = 9'd1;
        req1[k] = 1'b1; we1[k] = '0; addr1[k] = 9'd2;
        for (int i = 0; i < 4; i++) begin
            #1;
            chk("lit_rr_gnt0", k, 64'(gnt0[k]), 64'(i % 2 == 0));
            chk("lit_rr_gnt1", k, 64'(gnt1[k]), 64'(i % 2 == 1));
            cyc();
            chk("lit_rr_rv0",  k, 64'(rvalid0[k]), 64'(i % 2 == 0));
            chk("lit_rr_rv1",  k, 64'(rvalid1[k]), 64'(i % 2 == 1));
            chk("lit_rr_dout", k, dout[k], pat(k, (i % 2 == 0) ? 1 : 2));
        end
        idle(k);
        cyc();

        // reset on the cycle after a read grant
        single(k, 0, 8'h00, 9'd1, 64'h0);
        cyc();
        #1 rst_n = 1'b0;
        #1;
        chk("lit_rst_rvalid", k, 64'(rvalid0[k]), 64'd0);
        chk("lit_rst_err",    k, 64'(err[k]),     64'd0);
        chk("lit_rst_dout",   k, dout[k],         64'd0);
        chk("lit_rst_gnt0",   k, 64'(gnt0[k]),    64'd0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        req1[k] = 1'b1; we1[k] = '0; addr1[k] = 9'd2;
        #1;
        chk("lit_post_rst_gnt0", k, 64'(gnt0[k]), 64'd1);
        chk("lit_post_rst_gnt1", k, 64'(gnt1[k]), 64'd0);
        cyc();
        idle(k);
        cyc();
    endtask

    initial begin
        for (int k = 0; k < 2; k++) begin
            idle(k);
            addr0[k] = '0; addr1[k] = '0;
            din0[k] = '0;  din1[k] = '0;
        end
        #2 rst_n = 1'b0;
        @(posedge clk);
        #1;
        for (int k = 0; k < 2; k++) begin
            chk("lit_reset_dout",    k, dout[k],          64'd0);
            chk("lit_reset_rvalid0", k, 64'(rvalid0[k]),  64'd0);
            chk("lit_reset_rvalid1", k, 64'(rvalid1[k]),  64'd0);
            chk("lit_reset_err",     k, 64'(err[k]),      64'd0);
        end
        @(posedge clk);
        #1 rst_n = 1'b1;

        // fill both arrays so every later read has a known value
        for (int k = 0; k < 2; k++) begin
            for (int a = 0; a < depth(k); a++) begin
                single(k, a % 2, 8'hFF, 9'(a), pat(k, a));
                cyc();
            end
            idle(k);
        end
        cyc();

        for (int k = 0; k < 2; k++) run_tests(k);

        cyc();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
